// File: rtl/data_mem.sv
// Byte-addressable big-endian data memory for the single-cycle datapath.
// Loads are combinational, stores commit at the clock edge, and illegal accesses are flagged and latched.
module data_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] Read_data,
  output logic        Misaligned,
  output logic        Fault,
  output logic [31:0] Fault_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  active;
  logic                  out_of_range;
  logic                  illegal;
  logic                  do_store;
  logic [3:0]            lane_en;
  logic [31:0]           lane_data;
  logic [31:0]           cur_word;
  logic [31:0]           next_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  assign idx          = Addr[ADDR_WIDTH+1:2];
  assign active       = MemRead | MemWrite;
  assign out_of_range = (Addr >> (ADDR_WIDTH + 2)) != 32'd0;

  always_comb begin
    illegal = 1'b1;
    case (MemSize)
      2'b00:   illegal = out_of_range;
      2'b01:   illegal = out_of_range | Addr[0];
      2'b10:   illegal = out_of_range | (Addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  assign Misaligned = active & illegal;
  assign do_store   = MemWrite & ~illegal & ~rst;

  // A per-word valid bit stands in for clearing the array on reset: unwritten words read as zero.
  assign cur_word = valid[idx] ? mem[idx] : 32'd0;

  always_comb begin
    lane_en   = 4'b1111;
    lane_data = Write_data;
    case (MemSize)
      2'b00: begin
        lane_en   = 4'b1000 >> Addr[1:0];
        lane_data = {4{Write_data[7:0]}};
      end
      2'b01: begin
        lane_en   = Addr[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{Write_data[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = Write_data;
      end
    endcase
  end

  always_comb begin
    next_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (lane_en[b]) next_word[b*8 +: 8] = lane_data[b*8 +: 8];
    end
  end

  always_comb begin
    rd_byte = cur_word[7:0];
    case (Addr[1:0])
      2'b00:   rd_byte = cur_word[31:24];
      2'b01:   rd_byte = cur_word[23:16];
      2'b10:   rd_byte = cur_word[15:8];
      default: rd_byte = cur_word[7:0];
    endcase
  end

  assign rd_half = Addr[1] ? cur_word[15:0] : cur_word[31:16];

  always_comb begin
    Read_data = 32'd0;
    if (MemRead && !illegal) begin
      case (MemSize)
        2'b00:   Read_data = {{24{MemSigned & rd_byte[7]}}, rd_byte};
        2'b01:   Read_data = {{16{MemSigned & rd_half[15]}}, rd_half};
        default: Read_data = cur_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) mem[idx] <= next_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      Fault      <= 1'b0;
      Fault_addr <= 32'd0;
    end else begin
      if (do_store) valid[idx] <= 1'b1;
      if (Misaligned && !Fault) begin
        Fault      <= 1'b1;
        Fault_addr <= Addr;
      end
    end
  end

endmodule
